exc_redirect_ctrl: RTL and testbench

//  Exception/interrupt initiator for CP0: sits at the M1 stage and drives CP0's m1s_ex/Exctype and pipeline flush.

---
 rtl/exc_redirect_ctrl.sv | 140 ++++++++++++++
 tb/tb_exc_redirect_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl: M1-stage exception/interrupt initiator for CP0.
// Arbitrates interrupts, exceptions and ERET, then hands the redirect PC to fetch.
module exc_redirect_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
  parameter logic [31:0] REFILL_VECTOR = 32'hBFC00200,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  ext_int,
  input  logic        cp0_status_ie,
  input  logic        cp0_status_exl,
  input  logic [7:0]  cp0_status_im,
  input  logic [7:0]  cp0_cause_ip,
  input  logic        cp0_cause_ti,
  input  logic [31:0] cp0_epc,
  input  logic        m1s_valid,
  input  logic        m1s_has_exc,
  input  logic [4:0]  m1s_exc_code,
  input  logic        m1s_inst_eret,
  output logic        m1s_ex,
  output logic [4:0]  Exctype,
  output logic [5:0]  int_ext_sync,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  // Exctype codes shared with CP0
  localparam logic [4:0] NO_EX             = 5'h1F;
  localparam logic [4:0] INT               = 5'h00;
  localparam logic [4:0] ITLB_EX_REFILL    = 5'h12;
  localparam logic [4:0] DTLB_EX_RD_REFILL = 5'h13;
  localparam logic [4:0] DTLB_EX_WR_REFILL = 5'h14;

  typedef enum logic [1:0] {
    IDLE,
    REDIR,
    SETTLE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [7:0]  hw_pend;
  logic        int_take;
  logic        eret_go;
  logic        is_refill;
  logic        refill_hit;
  logic [31:0] target;
  logic        unused_ip;

  assign unused_ip = ^cp0_cause_ip[7:2];

  // ext_int synchroniser; oldest stage feeds CP0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_int};
    end
  end

  assign int_ext_sync = sync_q[SYNC_STAGES-1];

  assign hw_pend = {int_ext_sync[5] | cp0_cause_ti,
                    int_ext_sync[4:0],
                    cp0_cause_ip[1:0]} & cp0_status_im;

  assign int_take = (|hw_pend) & cp0_status_ie
                  & ~cp0_status_exl;

  // Arbitration: interrupt > instruction exception > ERET
  always_comb begin
    m1s_ex  = 1'b0;
    Exctype = NO_EX;
    eret_go = 1'b0;
    if (state == IDLE) begin
      m1s_ex  = m1s_valid
              & (int_take | m1s_has_exc);
      Exctype = int_take ? INT
              : (m1s_has_exc ? m1s_exc_code : NO_EX);
      eret_go = m1s_valid & m1s_inst_eret
              & ~m1s_ex;
    end
  end

  assign flush = m1s_ex | eret_go;

  assign is_refill = (Exctype == ITLB_EX_REFILL)
                   | (Exctype == DTLB_EX_RD_REFILL)
                   | (Exctype == DTLB_EX_WR_REFILL);

  assign refill_hit = m1s_ex & is_refill
                    & ~cp0_status_exl;

  // Redirect target; ERET and refill are exclusive
  always_comb begin
    target = EXC_VECTOR;
    unique case (1'b1)
      eret_go:    target = cp0_epc;
      refill_hit: target = REFILL_VECTOR;
      default:    target = EXC_VECTOR;
    endcase
  end

  // Redirect handshake FSM with one settle cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush) begin
            state          <= REDIR;
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
          end
        end
        REDIR: begin
          if (redirect_ready) begin
            state          <= SETTLE;
            redirect_valid <= 1'b0;
          end
        end
        SETTLE: begin
          state <= IDLE;
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// tb_exc_redirect_ctrl: directed plus random checks
// against a cycle-level reference model.
module tb_exc_redirect_ctrl;

  localparam logic [31:0] EXC  = 32'hBFC00380;
  localparam logic [31:0] RFL  = 32'hBFC00200;
  localparam int          SS   = 2;
  localparam logic [4:0]  C_NO = 5'h1F;
  localparam logic [4:0]  C_IN = 5'h00;
  localparam logic [4:0]  C_IT = 5'h12;
  localparam logic [4:0]  C_DR = 5'h13;
  localparam logic [4:0]  C_DW = 5'h14;

  logic        clk;
  logic        resetn;
  logic [5:0]  ext_int;
  logic        ie;
  logic        exl;
  logic [7:0]  im;
  logic [7:0]  ip;
  logic        ti;
  logic [31:0] epc;
  logic        valid;
  logic        has;
  logic [4:0]  code;
  logic        eret;
  logic        m1s_ex;
  logic [4:0]  Exctype;
  logic [5:0]  int_ext_sync;
  logic        flush;
  logic        rv;
  logic [31:0] rpc;
  logic        ready;

  int total;
  int bad;

  // reference model: sampled ext_int history,
  // redirect outstanding, cooldown, latched target
  logic [5:0]  hist[$];
  bit          m_wait;
  bit          m_cool;
  logic [31:0] m_pc;

  exc_redirect_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .ext_int        (ext_int),
    .cp0_status_ie  (ie),
    .cp0_status_exl (exl),
    .cp0_status_im  (im),
    .cp0_cause_ip   (ip),
    .cp0_cause_ti   (ti),
    .cp0_epc        (epc),
    .m1s_valid      (valid),
    .m1s_has_exc    (has),
    .m1s_exc_code   (code),
    .m1s_inst_eret  (eret),
    .m1s_ex         (m1s_ex),
    .Exctype        (Exctype),
    .int_ext_sync   (int_ext_sync),
    .flush          (flush),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .redirect_ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    ext_int = '0; ie = 0; exl = 0; im = '0;
    ip = '0; ti = 0; epc = '0; valid = 0;
    has = 0; code = '0; eret = 0; ready = 0;
  endtask

  task automatic model_clear();
    hist.delete();
    m_wait = 0;
    m_cool = 0;
    m_pc   = '0;
  endtask

  // check outputs against model, then advance one cycle
  task automatic step();
    logic [5:0]  s;
    logic [7:0]  pend;
    logic        it, ex, er, fl;
    logic [4:0]  ty;
    logic [31:0] tg;
    bit          idle;
    #1;
    s = (hist.size() >= SS) ? hist[hist.size()-SS] : 6'd0;
    pend = {s[5] | ti, s[4:0], ip[1:0]} & im;
    it = (pend != 0) && ie && !exl;
    idle = !m_wait && !m_cool;
    ex = 0; er = 0; ty = C_NO;
    if (idle) begin
      ex = valid && (it || has);
      if (it) ty = C_IN;
      else if (has) ty = code;
      er = valid && eret && !ex;
    end
    fl = ex || er;
    if (er) tg = epc;
    else if (ex && !exl &&
             (ty == C_IT || ty == C_DR || ty == C_DW))
      tg = RFL;
    else tg = EXC;
    chk("m1s_ex", 32'(m1s_ex), 32'(ex));
    chk("exctype", 32'(Exctype), 32'(ty));
    chk("flush", 32'(flush), 32'(fl));
    chk("sync", 32'(int_ext_sync), 32'(s));
    chk("rvalid", 32'(rv), 32'(m_wait));
    chk("rpc", rpc, m_pc);
    @(posedge clk);
    hist.push_back(ext_int);
    if (hist.size() > 4) void'(hist.pop_front());
    if (m_wait) begin
      if (ready) begin
        m_wait = 0;
        m_cool = 1;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (fl) begin
      m_wait = 1;
      m_pc   = tg;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    quiet();
    resetn = 0;
    #1;
    model_clear();
    chk("rst_ex", 32'(m1s_ex), 32'd0);
    chk("rst_type", 32'(Exctype), 32'(C_NO));
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_rv", 32'(rv), 32'd0);
    chk("rst_pc", rpc, 32'd0);
    chk("rst_sync", 32'(int_ext_sync), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic release_redir();
    valid = 0; has = 0; eret = 0;
    ready = 1;
    step();
    ready = 0;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    do_reset();

    // interrupt through the synchroniser
    ie = 1; im = 8'h04; valid = 1;
    ext_int = 6'h01;
    #1 chk("t1_early0", 32'(m1s_ex), 32'd0);
    step();
    #1 chk("t1_early1", 32'(m1s_ex), 32'd0);
    step();
    #1 chk("t1_ex", 32'(m1s_ex), 32'd1);
    chk("t1_type", 32'(Exctype), 32'(C_IN));
    step();
    chk("t1_rv", 32'(rv), 32'd1);
    chk("t1_pc", rpc, EXC);
    ext_int = 0;
    ie = 0;
    release_redir();

    // refill vector only with EXL clear
    valid = 1; has = 1; code = C_DR; exl = 0;
    step();
    chk("t2_pc_rfl", rpc, RFL);
    release_redir();
    valid = 1; has = 1; code = C_DR; exl = 1;
    step();
    chk("t2_pc_exc", rpc, EXC);
    release_redir();
    exl = 0;

    // ERET with stalled fetch; M1 exceptions ignored
    valid = 1; eret = 1; epc = 32'h80001234;
    #1 chk("t3_flush", 32'(flush), 32'd1);
    step();
    has = 1; code = 5'h05;
    for (int i = 0; i < 5; i++) begin
      epc = $urandom;
      #1 chk("t3_rv", 32'(rv), 32'd1);
      chk("t3_pc", rpc, 32'h80001234);
      chk("t3_noex", 32'(m1s_ex), 32'd0);
      chk("t3_nofl", 32'(flush), 32'd0);
      step();
    end
    release_redir();

    // minimum turnaround: next exception at T+3
    eret = 0; valid = 1; has = 1; code = 5'h05;
    step();
    ready = 1;
    #1 chk("t5_t1", 32'(m1s_ex), 32'd0);
    step();
    ready = 0;
    #1 chk("t5_t2", 32'(m1s_ex), 32'd0);
    chk("t5_rv_low", 32'(rv), 32'd0);
    step();
    #1 chk("t5_t3", 32'(m1s_ex), 32'd1);
    step();
    release_redir();

    // interrupt beats ERET
    valid = 1; eret = 1; epc = 32'h80005678;
    ie = 1; im = 8'h01; ip = 8'h01;
    #1 chk("t4_type", 32'(Exctype), 32'(C_IN));
    step();
    chk("t4_pc", rpc, EXC);
    ip = 0; ie = 0;
    release_redir();

    // async reset while redirect outstanding
    valid = 1; has = 1; code = 5'h05;
    step();
    chk("t6_rv_pre", 32'(rv), 32'd1);
    valid = 0; has = 0;
    #2 resetn = 0;
    #1;
    model_clear();
    chk("t6_rv", 32'(rv), 32'd0);
    chk("t6_pc", rpc, 32'd0);
    chk("t6_ex", 32'(m1s_ex), 32'd0);
    chk("t6_type", 32'(Exctype), 32'(C_NO));
    @(negedge clk);
    resetn = 1;
    step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] pick[6];
      pick = '{C_IT, C_DR, C_DW, 5'h05, 5'h0A, 5'h04};
      if ($urandom_range(3) == 0) ext_int = 6'($urandom);
      ie    = 1'($urandom);
      exl   = ($urandom_range(3) == 0);
      im    = 8'($urandom);
      ip    = 8'($urandom);
      ti    = ($urandom_range(7) == 0);
      epc   = $urandom;
      valid = 1'($urandom);
      has   = ($urandom_range(3) == 0);
      code  = pick[$urandom_range(5)];
      eret  = ($urandom_range(3) == 0);
      ready = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
